// File: rtl/spw_credit_buffer_if.sv
// Signal bundle between the SpaceWire credit buffer and its RX/TX/FSM/host neighbours.
// The DUT uses the slave modport; whoever drives the events and reads the FIFO uses master.
interface spw_credit_buffer_if #(
  parameter int DATA_W     = 9,
  parameter int DEPTH      = 64,
  parameter int MAX_CREDIT = 56
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_CREDIT + 1);

  logic              link_run;
  logic              rx_nchar_valid;
  logic [DATA_W-1:0] rx_nchar_data;
  logic              rx_got_fct;
  logic              fct_req;
  logic              fct_sent;
  logic              tx_nchar_sent;
  logic              tx_credit_avail;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_empty;
  logic [AW:0]       fifo_count;
  logic [CW-1:0]     rx_credit;
  logic [CW-1:0]     tx_credit;
  logic              credit_error;

  modport slave (
    input  link_run, rx_nchar_valid, rx_nchar_data, rx_got_fct, fct_sent,
           tx_nchar_sent, rd_en,
    output fct_req, tx_credit_avail, rd_data, rd_empty, fifo_count,
           rx_credit, tx_credit, credit_error
  );

  modport master (
    output link_run, rx_nchar_valid, rx_nchar_data, rx_got_fct, fct_sent,
           tx_nchar_sent, rd_en,
    input  fct_req, tx_credit_avail, rd_data, rd_empty, fifo_count,
           rx_credit, tx_credit, credit_error
  );
endinterface

// File: rtl/spw_credit_buffer.sv
// SpaceWire credit/flow-control engine with integrated RX N-char FIFO.
// Grants credit to the far end via FCT requests and tracks credit it has granted us.
module spw_credit_buffer #(
  parameter int DATA_W     = 9,
  parameter int DEPTH      = 64,
  parameter int FCT_CHARS  = 8,
  parameter int MAX_CREDIT = 56
) (
  input  logic              pclk,
  input  logic              resetn,
  spw_credit_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_CREDIT + 1);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [CW:0] FCT_V   = (CW + 1)'(FCT_CHARS);
  localparam logic [CW:0] MAX_V   = (CW + 1)'(MAX_CREDIT);

  typedef enum logic {
    FCT_IDLE,
    FCT_REQ
  } fct_state_e;

  fct_state_e        state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [CW-1:0]     rx_credit_q, rx_credit_d;
  logic [CW-1:0]     tx_credit_q, tx_credit_d;
  logic              error_q, error_d;

  logic        fct_ack;
  logic        wr_req, wr_en, rd_fire, fifo_full;
  logic        rx_err, tx_ovf, tx_got, tx_sent;
  logic [CW:0] rx_avail, tx_net;
  logic [AW:0] free_space;

  assign fifo_full  = (count_q == DEPTH_V);
  assign free_space = DEPTH_V - count_q;
  assign rd_fire    = bus.rd_en && (count_q != '0);
  // fct_sent only counts while a request is actually outstanding in Run.
  assign fct_ack    = bus.link_run && (state_q == FCT_REQ) && bus.fct_sent;

  // NOTE: always_comb with every output given a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FCT_IDLE: begin
        if (bus.link_run
            && (int'(rx_credit_q) <= MAX_CREDIT - FCT_CHARS)
            && (int'(free_space) >= int'(rx_credit_q) + FCT_CHARS))
          state_d = FCT_REQ;
      end
      FCT_REQ: begin
        if (!bus.link_run || bus.fct_sent)
          state_d = FCT_IDLE;
      end
      default: state_d = FCT_IDLE;
    endcase
  end

  // RX side: credit from a simultaneous FCT ack is available to the arriving N-char.
  always_comb begin
    wr_req      = bus.link_run && bus.rx_nchar_valid;
    rx_avail    = {1'b0, rx_credit_q} + (fct_ack ? FCT_V : '0);
    wr_en       = wr_req && (rx_avail != '0) && !fifo_full;
    rx_err      = wr_req && !wr_en;
    rx_credit_d = '0;
    if (bus.link_run)
      rx_credit_d = CW'(rx_avail - {{CW{1'b0}}, wr_en});
  end

  // TX side: a lone send at zero credit is ignored; overflow is judged on the net result.
  always_comb begin
    tx_got      = bus.link_run && bus.rx_got_fct;
    tx_sent     = bus.link_run && bus.tx_nchar_sent && (tx_got || (tx_credit_q != '0));
    tx_net      = {1'b0, tx_credit_q} + (tx_got ? FCT_V : '0) - {{CW{1'b0}}, tx_sent};
    tx_ovf      = tx_got && (tx_net > MAX_V);
    tx_credit_d = '0;
    if (bus.link_run)
      tx_credit_d = tx_ovf ? tx_credit_q : CW'(tx_net);
  end

  always_comb begin
    wr_ptr_d = wr_en   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_fire};
    error_d  = rx_err || tx_ovf;
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FCT_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rx_credit_q <= '0;
      tx_credit_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_credit_q <= rx_credit_d;
      tx_credit_q <= tx_credit_d;
      error_q     <= error_d;
      if (rd_fire)
        rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // NOTE: storage array has no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge pclk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= bus.rx_nchar_data;
  end

  assign bus.fct_req         = (state_q == FCT_REQ);
  assign bus.tx_credit_avail = (tx_credit_q != '0);
  assign bus.rd_data         = rd_data_q;
  assign bus.rd_empty        = (count_q == '0);
  assign bus.fifo_count      = count_q;
  assign bus.rx_credit       = rx_credit_q;
  assign bus.tx_credit       = tx_credit_q;
  assign bus.credit_error    = error_q;

endmodule

// File: tb/tb_spw_credit_buffer.sv
// Self-checking bench for spw_credit_buffer: credit bookkeeping checks plus a
// scoreboard queue that follows every accepted N-char through the FIFO.
module tb_spw_credit_buffer;
  localparam int DATA_W     = 9;
  localparam int DEPTH      = 64;
  localparam int FCT_CHARS  = 8;
  localparam int MAX_CREDIT = 56;

  logic pclk;
  logic resetn;

  spw_credit_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_CREDIT(MAX_CREDIT)) bus ();

  spw_credit_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FCT_CHARS(FCT_CHARS), .MAX_CREDIT(MAX_CREDIT)
  ) dut (
    .pclk   (pclk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_cmp  = 0;
  int n_mism = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mism++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_pulses();
    bus.rx_nchar_valid = 1'b0;
    bus.rx_got_fct     = 1'b0;
    bus.fct_sent       = 1'b0;
    bus.tx_nchar_sent  = 1'b0;
    bus.rd_en          = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge pclk);
    #1;
    clear_pulses();
  endtask

  task automatic wait_fct_req(input string tag);
    for (int i = 0; i < 20 && !bus.fct_req; i++) tick();
    check(tag, int'(bus.fct_req), 1);
  endtask

  task automatic write_char(input logic [DATA_W-1:0] d, input bit accept);
    bus.rx_nchar_valid = 1'b1;
    bus.rx_nchar_data  = d;
    if (accept) exp_q.push_back(d);
    tick();
  endtask

  task automatic read_char(input string tag);
    logic [DATA_W-1:0] e;
    bus.rd_en = 1'b1;
    tick();
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, int'(bus.rd_data), int'(e));
    end
  endtask

  initial begin
    resetn            = 1'b0;
    bus.link_run      = 1'b0;
    bus.rx_nchar_data = '0;
    clear_pulses();
    repeat (3) @(posedge pclk);
    #1;
    check("rst_rx_credit", int'(bus.rx_credit), 0);
    check("rst_tx_credit", int'(bus.tx_credit), 0);
    check("rst_fct_req",   int'(bus.fct_req), 0);
    check("rst_rd_empty",  int'(bus.rd_empty), 1);
    check("rst_count",     int'(bus.fifo_count), 0);
    check("rst_error",     int'(bus.credit_error), 0);
    check("rst_tx_avail",  int'(bus.tx_credit_avail), 0);
    resetn = 1'b1;
    tick();

    bus.link_run = 1'b1;
    tick();
    tick();
    check("run_fct_req", int'(bus.fct_req), 1);

    // No credit granted yet: the N-char is dropped with a one-cycle error.
    write_char(9'h0AA, 1'b0);
    check("nocred_error", int'(bus.credit_error), 1);
    check("nocred_count", int'(bus.fifo_count), 0);
    tick();
    check("nocred_error_clr", int'(bus.credit_error), 0);

    for (int k = 0; k < 7; k++) begin
      wait_fct_req("ack_wait");
      bus.fct_sent = 1'b1;
      tick();
    end
    check("full_grant_rx_credit", int'(bus.rx_credit), 56);
    repeat (3) tick();
    check("full_grant_no_req", int'(bus.fct_req), 0);
    bus.fct_sent = 1'b1;
    tick();
    check("stray_ack_ignored", int'(bus.rx_credit), 56);

    for (int k = 0; k < 56; k++)
      write_char(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), 1'b1);
    check("fill_rx_credit", int'(bus.rx_credit), 0);
    check("fill_count",     int'(bus.fifo_count), 56);
    write_char(9'h155, 1'b0);
    check("fill_drop_error", int'(bus.credit_error), 1);
    check("fill_drop_count", int'(bus.fifo_count), 56);

    for (int k = 0; k < 8; k++) read_char("fifo_data_a");
    check("after_read_count", int'(bus.fifo_count), 48);
    wait_fct_req("after_read_req");
    bus.fct_sent = 1'b1;
    tick();
    check("after_ack_rx_credit", int'(bus.rx_credit), 8);

    wait_fct_req("simul_req");
    bus.fct_sent = 1'b1;
    write_char(9'h1C3, 1'b1);
    check("simul_rx_credit", int'(bus.rx_credit), 15);
    check("simul_no_error",  int'(bus.credit_error), 0);
    check("simul_count",     int'(bus.fifo_count), 49);

    for (int k = 0; k < 7; k++) begin
      bus.rx_got_fct = 1'b1;
      tick();
    end
    check("tx_fill_credit", int'(bus.tx_credit), 56);
    check("tx_fill_avail",  int'(bus.tx_credit_avail), 1);
    bus.rx_got_fct = 1'b1;
    tick();
    check("tx_ovf_error",  int'(bus.credit_error), 1);
    check("tx_ovf_credit", int'(bus.tx_credit), 56);

    for (int k = 0; k < 7; k++) begin
      bus.tx_nchar_sent = 1'b1;
      tick();
    end
    check("tx_spend_credit", int'(bus.tx_credit), 49);
    bus.rx_got_fct    = 1'b1;
    bus.tx_nchar_sent = 1'b1;
    tick();
    check("tx_net_credit",   int'(bus.tx_credit), 56);
    check("tx_net_no_error", int'(bus.credit_error), 0);
    bus.rx_got_fct    = 1'b1;
    bus.tx_nchar_sent = 1'b1;
    tick();
    check("tx_net_ovf_error",  int'(bus.credit_error), 1);
    check("tx_net_ovf_credit", int'(bus.tx_credit), 56);

    // Leaving Run with credit events in flight: all ignored, no error.
    bus.link_run       = 1'b0;
    bus.rx_got_fct     = 1'b1;
    bus.rx_nchar_valid = 1'b1;
    bus.rx_nchar_data  = 9'h0F0;
    bus.fct_sent       = 1'b1;
    tick();
    check("down_rx_credit", int'(bus.rx_credit), 0);
    check("down_tx_credit", int'(bus.tx_credit), 0);
    check("down_fct_req",   int'(bus.fct_req), 0);
    check("down_no_error",  int'(bus.credit_error), 0);
    check("down_count",     int'(bus.fifo_count), 49);

    for (int k = 0; k < 49; k++) read_char("fifo_data_b");
    check("drain_empty", int'(bus.rd_empty), 1);
    bus.rd_en = 1'b1;
    tick();
    check("empty_read_count", int'(bus.fifo_count), 0);

    bus.link_run = 1'b1;
    tick();
    bus.tx_nchar_sent = 1'b1;
    tick();
    check("tx_underflow_credit", int'(bus.tx_credit), 0);
    check("tx_underflow_error",  int'(bus.credit_error), 0);
    bus.rx_got_fct = 1'b1;
    tick();
    check("tx_one_fct", int'(bus.tx_credit), 8);

    write_char(9'h011, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_tx",    int'(bus.tx_credit), 0);
    check("async_rst_req",   int'(bus.fct_req), 0);
    check("async_rst_error", int'(bus.credit_error), 0);
    check("async_rst_empty", int'(bus.rd_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
